// File: rtl/hc_sr04_pkg.sv
// Shared types and constants for the HC-SR04 ultrasonic ranger core.
// Optional echo timeout is enabled with `define HC_SR04_TIMEOUT_EN.
`timescale 1ns/1ps
package hc_sr04_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG      = 3'd1,
      ST_WAIT_ECHO = 3'd2,
      ST_MEASURE   = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   localparam logic [4:0] REG_DIST   = 5'd0;
   localparam logic [4:0] REG_STATUS = 5'd1;

   localparam int STAT_READY   = 0;
   localparam int STAT_BUSY    = 1;
   localparam int STAT_TIMEOUT = 2;

   localparam int unsigned DEF_TRIG_CYCLES    = 1000;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 3_800_000;

   localparam logic [31:0] DIST_MAX = 32'hFFFF_FFFF;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == DIST_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hc_sr04_sync.sv
// Two-flop synchronizer bringing the asynchronous echo line into the clk domain.
`timescale 1ns/1ps
module hc_sr04_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/hc_sr04_core.sv
// HC-SR04 ranger: bus-started trigger pulse, echo width measurement, register readback.
// Define HC_SR04_TIMEOUT_EN to abort a measurement after TIMEOUT_CYCLES in WAIT_ECHO/MEASURE.
`timescale 1ns/1ps
module hc_sr04_core
   import hc_sr04_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        trigger,
   input  logic        echo
);

   state_e      r_state;
   logic [31:0] r_trig_cnt;
   logic [31:0] r_count;
   logic [31:0] r_dist;
   logic        r_trigger;
   logic        r_ready;
   logic        r_armed;

   logic        w_echo_s;
   logic        w_start;
   logic        w_busy;
   logic        w_to_hit;
   logic        w_timeout;
   logic        w_unused;

   hc_sr04_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (echo),
      .o_sync  (w_echo_s)
   );

   assign w_start = cs && write && (addr == REG_DIST) &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_busy  = (r_state == ST_TRIG) || (r_state == ST_WAIT_ECHO) || (r_state == ST_MEASURE);

`ifdef HC_SR04_TIMEOUT_EN
   logic [31:0] r_to_cnt;
   logic        r_timeout;

   assign w_to_hit = ((r_state == ST_WAIT_ECHO) || (r_state == ST_MEASURE)) &&
                     (r_to_cnt == TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if ((r_state == ST_WAIT_ECHO) || (r_state == ST_MEASURE)) begin
            r_to_cnt <= r_to_cnt + 32'd1;
         end else begin
            r_to_cnt <= '0;
         end
         if (w_start) begin
            r_timeout <= 1'b0;
         end else if (w_to_hit) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign w_timeout = r_timeout;
   assign w_unused  = ^{read, wr_data};
`else
   assign w_to_hit  = 1'b0;
   assign w_timeout = 1'b0;
   assign w_unused  = ^{read, wr_data, TIMEOUT_CYCLES};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_trig_cnt <= '0;
         r_count    <= '0;
         r_dist     <= '0;
         r_trigger  <= 1'b0;
         r_ready    <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start) begin
                  r_state    <= ST_TRIG;
                  r_trigger  <= 1'b1;
                  r_trig_cnt <= '0;
                  r_count    <= '0;
                  r_ready    <= 1'b0;
               end
            end
            ST_TRIG: begin
               if (r_trig_cnt == TRIG_CYCLES - 1) begin
                  r_state   <= ST_WAIT_ECHO;
                  r_trigger <= 1'b0;
                  r_armed   <= 1'b0;
               end else begin
                  r_trig_cnt <= r_trig_cnt + 32'd1;
               end
            end
            // An echo already high on entry must be seen low (armed) before it can start a measurement.
            ST_WAIT_ECHO: begin
               if (w_to_hit) begin
                  r_dist  <= DIST_MAX;
                  r_ready <= 1'b1;
                  r_state <= ST_DONE;
               end else if (!w_echo_s) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_state <= ST_MEASURE;
                  r_count <= 32'd1;
               end
            end
            ST_MEASURE: begin
               if (!w_echo_s) begin
                  r_dist  <= r_count;
                  r_ready <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_to_hit) begin
                  r_dist  <= DIST_MAX;
                  r_ready <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_count <= sat_inc(r_count);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign trigger = r_trigger;

   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      rd_data = '0;
      case (addr)
         REG_DIST: rd_data = r_dist;
         REG_STATUS: begin
            rd_data[STAT_READY]   = r_ready;
            rd_data[STAT_BUSY]    = w_busy;
            rd_data[STAT_TIMEOUT] = w_timeout;
         end
         default: rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_hc_sr04_core.sv
// Self-checking bench for hc_sr04_core: register map tables, directed corner sequences, random echo pulses.
`timescale 1ns/1ps
module tb_hc_sr04_core;
   import hc_sr04_pkg::*;

   localparam int unsigned TB_TRIG    = 1000;
   localparam int unsigned TB_TIMEOUT = 5000;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        trigger;
   logic        echo;

   int n_total = 0;
   int n_bad   = 0;
   int trig_hi_seen;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] exp;
      int unsigned tol;
   } vec_t;

   hc_sr04_core #(
      .TRIG_CYCLES    (TB_TRIG),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .read    (read),
      .write   (write),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .trigger (trigger),
      .echo    (echo)
   );

   always #5 clk = ~clk;

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish (got running, want finished)");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                        input int unsigned tol = 0);
      longint diff;
      n_total++;
      diff = longint'({32'd0, act}) - longint'({32'd0, exp});
      if (diff < 0) diff = -diff;
      if ($isunknown(act) || diff > longint'(tol)) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h (%0d), want 0x%08h (%0d) +/-%0d", name, act, act, exp, exp, tol);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rd_data;
   endtask

   task automatic start_cmd();
      cs = 1'b1; write = 1'b1; addr = REG_DIST; wr_data = $urandom;
      step(1);
      cs = 1'b0; write = 1'b0; wr_data = '0;
   endtask

   // Counts sampled cycles with trigger high, bounded so a stuck trigger cannot hang the run.
   task automatic wait_trigger(output int n);
      n = 0;
      while (trigger === 1'b1 && n < 3 * int'(TB_TRIG)) begin
         n++;
         step(1);
      end
   endtask

   task automatic echo_pulse(input int w, input bit do_mid, input logic [4:0] waddr);
      echo = 1'b1;
      for (int i = 0; i < w; i++) begin
         if (do_mid && i == w / 2) begin
            cs = 1'b1; write = 1'b1; addr = waddr; wr_data = $urandom;
         end
         step(1);
         cs = 1'b0; write = 1'b0;
         if (trigger !== 1'b0) trig_hi_seen++;
      end
      echo = 1'b0;
   endtask

   initial begin
      vec_t        vecs [5];
      logic [31:0] d;
      int          n;
      int          npre;

      reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
      addr = '0; wr_data = '0; echo = 1'b0;
      step(10);

      // Register map while reset is held: everything reads zero.
      vecs[0] = '{5'd0,  32'd0, 0};
      vecs[1] = '{5'd1,  32'd0, 0};
      vecs[2] = '{5'd2,  32'd0, 0};
      vecs[3] = '{5'd17, 32'd0, 0};
      vecs[4] = '{5'd31, 32'd0, 0};
      for (int i = 0; i < 5; i++) begin
         rd(vecs[i].addr, d);
         check($sformatf("reset_rd[a=%0d]", vecs[i].addr), d, vecs[i].exp, vecs[i].tol);
         step(1);
      end
      check("reset_trigger", {31'd0, trigger}, 32'd0);
      reset = 1'b0;
      step(1);

      // Basic measurement: 200 us echo at 100 MHz.
      start_cmd();
      rd(REG_STATUS, d);
      check("basic_busy_after_start", d, 32'b010);
      wait_trigger(n);
      check("basic_trig_width", 32'(n), TB_TRIG);
      step(500);
      echo = 1'b1;
      step(20000);
      echo = 1'b0;
      step(100);
      vecs[0] = '{5'd0,  32'd20000, 1};
      vecs[1] = '{5'd1,  32'b001,   0};
      vecs[2] = '{5'd2,  32'd0,     0};
      vecs[3] = '{5'd7,  32'd0,     0};
      vecs[4] = '{5'd31, 32'd0,     0};
      for (int i = 0; i < 5; i++) begin
         rd(vecs[i].addr, d);
         check($sformatf("basic_rd[a=%0d]", vecs[i].addr), d, vecs[i].exp, vecs[i].tol);
         step(1);
      end

      // Start write during MEASURE is ignored.
      start_cmd();
      wait_trigger(n);
      check("midstart_trig_width", 32'(n), TB_TRIG);
      step(200);
      trig_hi_seen = 0;
      echo_pulse(150, 1'b1, REG_DIST);
      step(20);
      check("midstart_trigger_stays_low", 32'(trig_hi_seen), 32'd0);
      rd(REG_DIST, d);
      check("midstart_dist", d, 32'd150, 1);
      rd(REG_STATUS, d);
      check("midstart_status", d, 32'b001);

      // Re-start from DONE: ready clears right after the write.
      start_cmd();
      rd(REG_STATUS, d);
      check("restart_ready_cleared", d, 32'b010);
      wait_trigger(n);
      check("restart_trig_width", 32'(n), TB_TRIG);
      step(500);
      echo_pulse(100, 1'b0, 5'd0);
      step(100);
      rd(REG_DIST, d);
      check("restart_dist", d, 32'd100, 1);

      // Echo already high when trigger ends: only the next full pulse counts.
      start_cmd();
      step(100);
      echo = 1'b1;
      wait_trigger(n);
      check("prehigh_trig_width", 32'(n + 100), TB_TRIG);
      step(300);
      echo = 1'b0;
      step(10);
      rd(REG_STATUS, d);
      check("prehigh_not_measured", d, 32'b010);
      step(40);
      echo_pulse(77, 1'b0, 5'd0);
      step(10);
      rd(REG_DIST, d);
      check("prehigh_dist", d, 32'd77, 1);
      rd(REG_STATUS, d);
      check("prehigh_status", d, 32'b001);

      // Reset during MEASURE aborts without setting ready.
      start_cmd();
      wait_trigger(n);
      step(50);
      echo = 1'b1;
      step(100);
      rd(REG_STATUS, d);
      check("rstmid_busy", d, 32'b010);
      reset = 1'b1;
      step(1);
      check("rstmid_trigger", {31'd0, trigger}, 32'd0);
      rd(REG_DIST, d);
      check("rstmid_dist", d, 32'd0);
      rd(REG_STATUS, d);
      check("rstmid_status", d, 32'd0);
      reset = 1'b0;
      step(20);
      echo = 1'b0;
      step(20);
      rd(REG_STATUS, d);
      check("rstmid_no_ready", d, 32'd0);
      rd(REG_DIST, d);
      check("rstmid_dist_after", d, 32'd0);

      // No echo at all.
      start_cmd();
      wait_trigger(n);
      step(int'(TB_TIMEOUT) - 100);
      rd(REG_STATUS, d);
      check("noecho_still_busy", d, 32'b010);
`ifdef HC_SR04_TIMEOUT_EN
      n = int'(TB_TIMEOUT) - 100;
      rd(REG_STATUS, d);
      while (d[STAT_READY] !== 1'b1 && n < int'(TB_TIMEOUT) + 500) begin
         step(1);
         n++;
         rd(REG_STATUS, d);
      end
      check("timeout_cycles", 32'(n), TB_TIMEOUT, 1);
      check("timeout_status", d, 32'b101);
      rd(REG_DIST, d);
      check("timeout_dist", d, 32'hFFFF_FFFF);
`else
      step(2000);
      rd(REG_STATUS, d);
      check("notimeout_waits", d, 32'b010);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
`endif

      // Random pulses against a width model: the first full pulse starting after trigger falls.
      for (int it = 0; it < 10; it++) begin
         bit          pre;
         bit          do_mid;
         int          dly;
         int          w;
         logic [4:0]  waddr;
         logic [4:0]  raddr;
         pre    = 1'($urandom_range(0, 1));
         do_mid = 1'($urandom_range(0, 1));
         dly    = int'($urandom_range(3, 200));
         w      = int'($urandom_range(1, 400));
         waddr  = 5'($urandom_range(1, 31));
         raddr  = 5'($urandom_range(2, 31));
         npre   = 0;
         start_cmd();
         if (pre) begin
            npre = int'($urandom_range(10, 500));
            step(npre);
            echo = 1'b1;
         end
         wait_trigger(n);
         check($sformatf("rand%0d_trig_width", it), 32'(n + npre), TB_TRIG);
         step(dly);
         if (pre) begin
            echo = 1'b0;
            step(int'($urandom_range(3, 40)));
         end
         echo_pulse(w, do_mid, waddr);
         step(10);
         rd(REG_DIST, d);
         check($sformatf("rand%0d_dist", it), d, 32'(w), 1);
         rd(REG_STATUS, d);
         check($sformatf("rand%0d_status", it), d, 32'b001);
         rd(raddr, d);
         check($sformatf("rand%0d_rd_a%0d", it, raddr), d, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
